// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong score/match logic.
package pong_pkg;

    typedef enum logic {
        ST_PLAY,
        ST_WON
    } state_t;

    localparam int SCORE_WIDTH_DEF = 4;

    // ceil(log2(n)), but never below 1 so single-entry indices still get a bit
    function automatic int clog2_min1(input int n);
        int unsigned r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : int'(r);
    endfunction

endpackage

// File: rtl/point_edge_detect.sv
// Rising-edge detector for level-style point requests, with multi-hot flag.
module point_edge_detect #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic             multi
);

    logic [WIDTH-1:0] prev;

    // prev also captures the live level during reset, so a request held
    // through reset is not seen as an edge afterwards.
    always_ff @(posedge clock) begin
        prev <= level;
    end

    always_comb begin
        rise  = reset ? '0 : (level & ~prev);
        multi = |(rise & (rise - WIDTH'(1)));
    end

endmodule

// File: rtl/score_keeper.sv
// N-player score and match controller: saturating scores, win-by margin,
// serve rotation and PLAY/WON tracking.
module score_keeper
    import pong_pkg::*;
#(
    parameter  int NUM_PLAYERS = 2,
    parameter  int SCORE_WIDTH = SCORE_WIDTH_DEF,
    parameter  int WIN_SCORE   = 11,
    parameter  int WIN_BY      = 2,
    parameter  int SERVE_EVERY = 2,
    localparam int IDX_W       = clog2_min1(NUM_PLAYERS)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_PLAYERS-1:0]             point_in,
    input  logic                               restart,
    output logic [NUM_PLAYERS*SCORE_WIDTH-1:0] scores,
    output logic                               game_over,
    output logic [IDX_W-1:0]                   winner,
    output logic [IDX_W-1:0]                   server,
    output logic                               point_accepted,
    output logic                               collision
);

    localparam int SMAX  = (1 << SCORE_WIDTH) - 1;
    localparam int CNT_W = clog2_min1(SERVE_EVERY);

    localparam logic [SCORE_WIDTH-1:0] SMAX_V    = SCORE_WIDTH'(SMAX);
    localparam logic [SCORE_WIDTH-1:0] WIN_V     = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [SCORE_WIDTH-1:0] DEUCE_V   = SCORE_WIDTH'(WIN_SCORE - 1);
    localparam logic signed [SCORE_WIDTH:0] WIN_BY_V = (SCORE_WIDTH+1)'(WIN_BY);
    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(SERVE_EVERY - 1);
    localparam logic [IDX_W-1:0]       SRV_LAST  = IDX_W'(NUM_PLAYERS - 1);

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8) begin : g_bad_players
        $error("score_keeper: NUM_PLAYERS must be 2..8");
    end
    if (WIN_SCORE < 1 || WIN_SCORE > SMAX) begin : g_bad_win
        $error("score_keeper: WIN_SCORE must be 1..2^SCORE_WIDTH-1");
    end
    if (WIN_BY < 1 || SERVE_EVERY < 1) begin : g_bad_margin
        $error("score_keeper: WIN_BY and SERVE_EVERY must be >= 1");
    end

    logic [NUM_PLAYERS-1:0] rise;
    logic                   multi;

    point_edge_detect #(
        .WIDTH(NUM_PLAYERS)
    ) u_edge (
        .clock (clock),
        .reset (reset),
        .level (point_in),
        .rise  (rise),
        .multi (multi)
    );

    state_t                                state_q, state_d;
    logic [NUM_PLAYERS-1:0][SCORE_WIDTH-1:0] score_q, score_d;
    logic [IDX_W-1:0]                      server_q, server_d;
    logic [IDX_W-1:0]                      winner_q, winner_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic                                  accepted_q, accepted_d;
    logic                                  collision_q, collision_d;

    logic [IDX_W-1:0]       idx;
    logic [SCORE_WIDTH-1:0] cur, s_p, best_other;
    logic signed [SCORE_WIDTH:0] lead;
    logic                   at_cap, win, deuce;

    // Candidate update for the single rising player; only used when one bit rose.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (rise[i]) idx = IDX_W'(i);
        end

        cur    = score_q[idx];
        at_cap = (cur == SMAX_V);
        s_p    = at_cap ? cur : cur + SCORE_WIDTH'(1);

        best_other = '0;
        deuce      = (s_p >= DEUCE_V);
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (IDX_W'(i) != idx) begin
                if (score_q[i] > best_other) best_other = score_q[i];
                if (score_q[i] < DEUCE_V)    deuce      = 1'b0;
            end
        end

        lead = $signed({1'b0, s_p}) - $signed({1'b0, best_other});
        win  = at_cap || ((s_p >= WIN_V) && (lead >= WIN_BY_V));
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        server_d    = server_q;
        winner_d    = winner_q;
        cnt_d       = cnt_q;
        accepted_d  = 1'b0;
        collision_d = 1'b0;

        if (restart) begin
            state_d  = ST_PLAY;
            score_d  = '0;
            server_d = '0;
            winner_d = '0;
            cnt_d    = '0;
        end else if (state_q == ST_PLAY) begin
            if (multi) begin
                collision_d = 1'b1;
            end else if (|rise) begin
                accepted_d   = 1'b1;
                score_d[idx] = s_p;
                if (win) begin
                    state_d  = ST_WON;
                    winner_d = idx;
                end else if (deuce || (cnt_q == CNT_LAST)) begin
                    cnt_d    = '0;
                    server_d = (server_q == SRV_LAST) ? '0 : server_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_PLAY;
            score_q     <= '0;
            server_q    <= '0;
            winner_q    <= '0;
            cnt_q       <= '0;
            accepted_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            server_q    <= server_d;
            winner_q    <= winner_d;
            cnt_q       <= cnt_d;
            accepted_q  <= accepted_d;
            collision_q <= collision_d;
        end
    end

    assign scores         = score_q;
    assign game_over      = (state_q == ST_WON);
    assign winner         = winner_q;
    assign server         = server_q;
    assign point_accepted = accepted_q;
    assign collision      = collision_q;

endmodule
